alarm_timer_ctrl: RTL

ALARM_TIMER_CTRL -- requirements
Module: alarm_timer_ctrl

---
 rtl/alarm_timer_ctrl.sv | 109 ++++++++++
 1 files changed

// File: rtl/alarm_timer_ctrl.sv
// Alarm timer: four reprogrammable 4-bit second slots feeding a one-shot countdown.
// Optional macro ALARM_TIMER_ZERO_REJECT_EN makes a reprogram with time_value == 0 leave the slot unchanged.
module alarm_timer_ctrl #(
   parameter int DIVIDER             = 27000000,
   parameter int T_ARM_DEFAULT       = 6,
   parameter int T_DRIVER_DEFAULT    = 8,
   parameter int T_PASSENGER_DEFAULT = 15,
   parameter int T_ALARM_DEFAULT     = 10
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start_timer,
   input  logic [1:0] interval,
   input  logic       reprogram,
   input  logic [1:0] time_param_sel,
   input  logic [3:0] time_value,
   output logic       expired,
   output logic [3:0] count,
   output logic       one_hz
);

   localparam int               DIV_W    = $clog2(DIVIDER);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIVIDER - 1);

   typedef enum logic {
      IDLE,
      COUNT
   } state_t;

   state_t           state, state_nxt;
   logic [DIV_W-1:0] div_cnt, div_nxt;
   logic [3:0]       count_nxt;
   logic             expired_nxt;
   logic [3:0]       slot [4];
   logic [3:0]       load_val;
   logic             slot_we;

   // The load reads the slot before any same-cycle reprogram lands.
   assign load_val = slot[interval];

`ifdef ALARM_TIMER_ZERO_REJECT_EN
   assign slot_we = reprogram && (time_value != 4'd0);
`else
   assign slot_we = reprogram;
`endif

   // NOTE: the slot file is only four registers with defined power-up values, so it is
   // reset like ordinary state; large RAM-style arrays would be left unreset instead.
   always_ff @(posedge clk) begin
      if (reset) begin
         slot[0] <= 4'(T_ARM_DEFAULT);
         slot[1] <= 4'(T_DRIVER_DEFAULT);
         slot[2] <= 4'(T_PASSENGER_DEFAULT);
         slot[3] <= 4'(T_ALARM_DEFAULT);
      end else if (slot_we) begin
         slot[time_param_sel] <= time_value;
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // pre-edge values; blocking assignments here would create ordering races.
   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         div_cnt <= '0;
         count   <= 4'd0;
         expired <= 1'b0;
      end else begin
         state   <= state_nxt;
         div_cnt <= div_nxt;
         count   <= count_nxt;
         expired <= expired_nxt;
      end
   end

   // NOTE: every signal written below gets a default first, so no path leaves
   // one unassigned and no latch is inferred.
   always_comb begin
      state_nxt   = state;
      div_nxt     = '0;
      count_nxt   = count;
      expired_nxt = 1'b0;
      one_hz      = (state == COUNT) && (div_cnt == DIV_LAST);

      if (start_timer) begin
         // A restart wins over a coincident tick; a zero load expires at once.
         count_nxt = load_val;
         if (load_val == 4'd0) begin
            expired_nxt = 1'b1;
            state_nxt   = IDLE;
         end else begin
            state_nxt   = COUNT;
         end
      end else if (state == COUNT) begin
         if (one_hz) begin
            if (count > 4'd1) begin
               count_nxt = count - 4'd1;
            end else begin
               count_nxt   = 4'd0;
               expired_nxt = 1'b1;
               state_nxt   = IDLE;
            end
         end else begin
            div_nxt = div_cnt + 1'b1;
         end
      end
   end

endmodule
